// File: rtl/spi_resp_pkg.sv
// Shared definitions for the SPI responder: command opcodes, the
// transaction state enum and the opcode-decode helper.
package spi_resp_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h0A;
  localparam logic [7:0] OP_REG_READ  = 8'h0B;
  localparam logic [7:0] OP_FIFO_READ = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    ADDR,
    DATA,
    IGNORE
  } state_e;

  // FIFO_READ is only a legal command when the sample FIFO is built in.
  function automatic logic is_valid_op(input logic [7:0] op, input logic fifo_en);
    return (op == OP_REG_READ) || (op == OP_WRITE) || (fifo_en && (op == OP_FIFO_READ));
  endfunction

endpackage

// File: rtl/spi_resp_fifo.sv
// Synchronous byte FIFO for the SPI responder sample path.
// Ports:
//   clk_i, rst_i      clock, async active-high reset (FIFO empties)
//   push_i, din_i     write strobe and byte
//   pop_i             remove head entry
//   dout_o            head entry (combinational read)
//   full_o, empty_o   occupancy flags
// A push while full is dropped unless a pop happens in the same cycle.
module spi_resp_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: instruction byte, address byte, then data bytes.
// Serves register reads (addr 0 reads DEVID), accepts register writes
// (addr 0 read-only) and drains an optional sample FIFO.
// Build option: define SPI_RESP_FIFO_EN to include the sample FIFO and the
// FIFO_READ (0x0D) command; without it 0x0D is ignored and FIFO_FULL is 0.
// Ports:
//   CLK, RST                 system clock, async active-high reset
//   SCLK, CS, MOSI           SPI pins (async, synchronised internally)
//   MISO, MISO_OE            SPI read data and output enable
//   LCL_WE/ADDR/WDATA        local register-file write port
//   FIFO_PUSH/DIN/FULL       sample FIFO fill side
//   WR_STB/ADDR/DATA         one-CLK report of each SPI-written byte
//   BUSY                     transaction in progress
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int         ADDR_W     = 6,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] DEVID      = 8'hAD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic              LCL_WE,
  input  logic [ADDR_W-1:0] LCL_ADDR,
  input  logic [7:0]        LCL_WDATA,
  input  logic              FIFO_PUSH,
  input  logic [7:0]        FIFO_DIN,
  output logic              FIFO_FULL,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              BUSY
);

`ifdef SPI_RESP_FIFO_EN
  localparam logic FIFO_EN = 1'b1;
`else
  localparam logic FIFO_EN = 1'b0;
`endif

  // Synchronisers: [0],[1] are the 2-FF chain, [2] is the edge-detect history.
  logic [2:0] sclk_q, cs_q, mosi_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      cs_q   <= {cs_q[1:0], CS};
      mosi_q <= {mosi_q[1:0], MOSI};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  assign sclk_rise = sclk_q[1] && !sclk_q[2];
  assign sclk_fall = !sclk_q[1] && sclk_q[2];
  assign cs_fall   = !cs_q[1] && cs_q[2];
  assign cs_rise   = cs_q[1] && !cs_q[2];
  assign mosi_s    = mosi_q[1];

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        sh_q, op_q, tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              miso_q;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        regs_q [2**ADDR_W];

  logic [7:0] rx_byte, tx_src, fifo_dout;
  logic       rx_active, byte_done, spi_we, tx_load, tx_shift, fifo_empty;

  assign rx_byte   = {sh_q[6:0], mosi_s};
  assign rx_active = (state_q == INSTR) || (state_q == ADDR) || (state_q == DATA);
  assign byte_done = sclk_rise && rx_active && (bit_cnt_q == 3'd7);
  assign spi_we    = byte_done && (state_q == DATA) && (op_q == OP_WRITE) && (addr_q != '0);

  // A new read byte is loaded on the first fall of each byte slot; the
  // remaining seven falls of the slot shift it out.
  assign tx_load  = sclk_fall && (state_q == DATA) && (op_q != OP_WRITE) && (bit_cnt_q == 3'd0);
  assign tx_shift = sclk_fall && (state_q == DATA) && (op_q != OP_WRITE) && (bit_cnt_q != 3'd0);

  always_comb begin
    tx_src = (addr_q == '0) ? DEVID : regs_q[addr_q];
    if (op_q == OP_FIFO_READ) tx_src = fifo_empty ? 8'h00 : fifo_dout;
  end

`ifdef SPI_RESP_FIFO_EN
  logic fifo_pop;
  assign fifo_pop = tx_load && (op_q == OP_FIFO_READ) && !fifo_empty;

  spi_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (FIFO_PUSH),
    .din_i  (FIFO_DIN),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (FIFO_FULL),
    .empty_o(fifo_empty)
  );
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic unused_fifo_in;
  assign unused_fifo_in = ^{FIFO_PUSH, FIFO_DIN};
  assign fifo_dout      = 8'h00;
  assign fifo_empty     = 1'b1;
  assign FIFO_FULL      = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = INSTR;
      INSTR:   if (byte_done) state_d = is_valid_op(rx_byte, FIFO_EN) ? ADDR : IGNORE;
      ADDR:    if (byte_done) state_d = DATA;
      default: state_d = state_q;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    BUSY    = (state_q != IDLE);
    MISO    = (state_q == DATA) ? miso_q : 1'b0;
    MISO_OE = !cs_q[1];
    WR_STB  = wr_stb_q;
    WR_ADDR = wr_addr_q;
    WR_DATA = wr_data_q;
  end

  // Receive shifter, address/opcode capture, transmit shifter, write report.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt_q <= '0;
      sh_q      <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_stb_q <= spi_we;
      if (spi_we) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end

      if (cs_fall) bit_cnt_q <= '0;
      else if (sclk_rise && rx_active) begin
        sh_q      <= rx_byte;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
        case (state_q)
          INSTR:   op_q   <= rx_byte;
          ADDR:    addr_q <= rx_byte[ADDR_W-1:0];
          DATA:    addr_q <= addr_q + 1'b1;
          default: ;
        endcase
      end

      if (state_q != DATA) begin
        tx_q   <= '0;
        miso_q <= 1'b0;
      end else if (tx_load) begin
        tx_q   <= tx_src;
        miso_q <= tx_src[7];
      end else if (tx_shift) begin
        tx_q   <= {tx_q[6:0], 1'b0};
        miso_q <= tx_q[6];
      end
    end
  end

  // Register file; the SPI write is ordered last so it wins an address collision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
    end else begin
      if (LCL_WE) regs_q[LCL_ADDR] <= LCL_WDATA;
      if (spi_we) regs_q[addr_q]   <= rx_byte;
    end
  end

endmodule
